sw_debounce: RTL and testbench
==============================

# sw_debounce

Debounce and edge-capture stage for the board push-switches `SW[3:0]`, sitting directly upstream of the MCU's `gpio_i` input port. Each raw switch is synchronised, filtered with a shared millisecond tick and a per-channel stability counter, and presented as a clean level plus sticky rise/fall event flags. The MCU clears the flags through a one-cycle clear strobe, and `irq` is raised while any enabled event is pending. Top-level mapping is `gpio_i = {sw_rise, sw_level}`.

## Interface
Parameters:
- `N_SW`, 4: number of switch channels.
- `TICK_DIV`, 12000: clocks per filter tick (1 ms at 12 MHz).
- `STABLE_TICKS`, 10: consecutive ticks a new level must persist before it is accepted. Must be ≥1.
- `RESET_LEVEL`, 1'b0: reset value of the synchronisers and `sw_level`.

Ports:
- `clk` in 1: system clock (12 MHz HFOSC).
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `sw_in` in N_SW: raw asynchronous switch pins.
- `clr_valid` in 1: one-cycle strobe that clears the events selected by `clr_mask`.
- `clr_mask` in N_SW: channel select for the clear.
- `irq_en` in N_SW: per-channel interrupt enable.
- `sw_level` out N_SW: debounced level.
- `sw_rise` out N_SW: sticky rising-edge flag.
- `sw_fall` out N_SW: sticky falling-edge flag.
- `irq` out 1: interrupt request, level-sensitive.

## Operation
- Synchroniser: two flops per channel, both reset to `RESET_LEVEL`. The second flop output is `sync`.
- Prescaler: counter `div` counts 0..TICK_DIV-1 and wraps. `tick` is high for exactly one cycle when `div == TICK_DIV-1`. The prescaler is shared by all channels and free-running.
- Per channel:
  - `cnt` has width `$clog2(STABLE_TICKS)`, minimum 1 bit.
  - If `sync == sw_level`, `cnt <= 0` in every cycle, tick or not. A bounce therefore restarts the filter immediately.
  - Else, on `tick`:
    - If `cnt == STABLE_TICKS-1`: `sw_level <= sync`, `cnt <= 0`, and set `sw_rise` (new level 1) or `sw_fall` (new level 0).
    - Otherwise: `cnt <= cnt+1`.
  - Else, with no tick: `cnt` holds.
- Event flags:
  - A flag is set by its edge.
  - A flag is cleared when `clr_valid && clr_mask[i]`.
  - If set and clear land in the same cycle, set wins; the flag stays 1.
  - Flags never clear themselves.
- `irq` is registered: `irq <= |((sw_rise | sw_fall) & irq_en)`.
- Reset values: `sw_level = RESET_LEVEL`, `sw_rise = 0`, `sw_fall = 0`, `irq = 0`, `div = 0`, `cnt = 0`.
- Reset asserted mid-filter discards all progress. After release, a pin that differs from `RESET_LEVEL` is debounced normally and produces its edge event.

## Timing
- `tick` first fires TICK_DIV-1 cycles after reset release, then every TICK_DIV cycles.
- Input-to-`sw_level` latency, for a clean step: 2 cycles of synchroniser plus between (STABLE_TICKS-1)·TICK_DIV+1 and STABLE_TICKS·TICK_DIV cycles.
- `sw_rise`/`sw_fall` assert in the same cycle `sw_level` changes.
- `irq` follows one cycle later.
- After a clear, `irq` deasserts one cycle after the flag drops.
- A pulse on the synchronised input shorter than STABLE_TICKS ticks never changes `sw_level`.

## Structure
- Shared package `icemcu_pkg` holds `CLK_HZ = 12_000_000` and `SW_TICK_DIV_1MS = CLK_HZ/1000`. The top level uses these for the parameter defaults.
- Sub-module `sw_debounce_chan` holds one channel: synchroniser, `cnt`, level, rise/fall flags. It takes `tick` as an input. The parent instantiates N_SW copies in a generate loop and owns the prescaler and the `irq` register.
- Target size is about 150 lines total.

## Test plan
Bench parameters: TICK_DIV=4, STABLE_TICKS=3, RESET_LEVEL=0.
- **Reset:** hold `rst_n` low with `sw_in=4'hF` → all outputs 0. Release; `sw_in=4'hF` held → `sw_level=4'hF` and `sw_rise=4'hF` between clock 11 and 14 after release; `sw_fall=0`.
- **Bounce rejection:** with channel 0 settled at 1, toggle `sw_in[0]` low for 6 clocks, then back high → `sw_level[0]` stays 1 and no `sw_fall`.
- **Clean fall plus irq:** `irq_en=4'b0001`, drive `sw_in[0]=0` steadily → `sw_fall[0]=1` within 14 clocks, `irq=1` one cycle later. Pulse `clr_valid` with `clr_mask=4'b0001` → `sw_fall[0]=0` next cycle, `irq=0` the cycle after.
- **Set/clear collision:** issue `clr_valid` with `clr_mask[1]=1` in the exact cycle channel 1 completes a rise → `sw_rise[1]` remains 1.
- **Masked irq:** event on channel 2 with `irq_en[2]=0` → flag sets, `irq` stays 0. Then set `irq_en[2]=1` → `irq=1` next cycle.
- **Reset mid-filter:** assert `rst_n` after 2 ticks of a pending change → outputs return to reset values at once, with no event after release until a full 3-tick filter completes.

Source files
------------

// File: rtl/icemcu_pkg.sv
// Shared constants for the iCE MCU board logic: system clock and derived prescaler defaults.
package icemcu_pkg;

    localparam int CLK_HZ          = 12_000_000;
    localparam int SW_TICK_DIV_1MS = CLK_HZ / 1000;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sw_debounce_chan.sv
// One switch channel: two-flop synchroniser, tick-based stability filter, sticky edge flags.
module sw_debounce_chan
    import icemcu_pkg::*;
#(
    parameter int   STABLE_TICKS = 10,
    parameter logic RESET_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_i,
    input  logic tick_i,
    input  logic clr_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int            CW       = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic          meta_q, sync_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          set_rise, set_fall;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
        level_d  = level_q;
        cnt_d    = cnt_q;
        set_rise = 1'b0;
        set_fall = 1'b0;
        if (sync_q == level_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == CNT_LAST) begin
                level_d  = sync_q;
                cnt_d    = '0;
                set_rise = sync_q;
                set_fall = ~sync_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        // A new edge beats a simultaneous clear.
        rise_d = set_rise | (rise_q & ~clr_i);
        fall_d = set_fall | (fall_q & ~clr_i);
    end

    // NOTE: the synchroniser flops are reset too, so a pin differing from RESET_LEVEL is filtered afresh after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= RESET_LEVEL;
            sync_q  <= RESET_LEVEL;
            level_q <= RESET_LEVEL;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let meta_q -> sync_q form a true two-stage shift.
            meta_q  <= sw_i;
            sync_q  <= meta_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/sw_debounce.sv
// Debounce/edge-capture for the board push-switches; shared ms prescaler, per-channel filters, registered irq.
module sw_debounce
    import icemcu_pkg::*;
#(
    parameter int   N_SW         = 4,
    parameter int   TICK_DIV     = SW_TICK_DIV_1MS,
    parameter int   STABLE_TICKS = 10,
    parameter logic RESET_LEVEL  = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_SW-1:0] sw_in,
    input  logic            clr_valid,
    input  logic [N_SW-1:0] clr_mask,
    input  logic [N_SW-1:0] irq_en,
    output logic [N_SW-1:0] sw_level,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
    output logic            irq
);

    localparam int            DW       = cnt_width(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    logic [DW-1:0]   div_q, div_d;
    logic            tick;
    logic            irq_q, irq_d;
    logic [N_SW-1:0] clr;

    assign tick  = (div_q == DIV_LAST);
    assign div_d = tick ? '0 : div_q + DW'(1);
    assign clr   = clr_valid ? clr_mask : '0;
    assign irq_d = |((sw_rise | sw_fall) & irq_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            irq_q <= 1'b0;
        end else begin
            div_q <= div_d;
            irq_q <= irq_d;
        end
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_chan
        sw_debounce_chan #(
            .STABLE_TICKS (STABLE_TICKS),
            .RESET_LEVEL  (RESET_LEVEL)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .sw_i    (sw_in[i]),
            .tick_i  (tick),
            .clr_i   (clr[i]),
            .level_o (sw_level[i]),
            .rise_o  (sw_rise[i]),
            .fall_o  (sw_fall[i])
        );
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce: startup table, directed corner cases, randomized run vs reference model.
module tb_sw_debounce;

    localparam int NS = 4;
    localparam int TD = 4;
    localparam int ST = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NS-1:0] sw_in;
    logic          clr_valid;
    logic [NS-1:0] clr_mask;
    logic [NS-1:0] irq_en;
    logic [NS-1:0] sw_level, sw_rise, sw_fall;
    logic          irq;

    int total = 0;
    int bad   = 0;

    sw_debounce #(
        .N_SW         (NS),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST),
        .RESET_LEVEL  (1'b0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_in     (sw_in),
        .clr_valid (clr_valid),
        .clr_mask  (clr_mask),
        .irq_en    (irq_en),
        .sw_level  (sw_level),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NS-1:0] sw;
        logic          clr_v;
        logic [NS-1:0] clr_m;
        logic [NS-1:0] en;
        logic [NS-1:0] level;
        logic [NS-1:0] rise;
        logic [NS-1:0] fall;
        logic          irq;
    } vec_t;

    vec_t tbl[16];

    // Reference model: a level flips once the synchronised pin has disagreed with it
    // through a run of cycles containing STABLE_TICKS ticks (tick on cycle c when c%TD==TD-1).
    logic [NS-1:0] m_s1, m_s2, m_level, m_rise, m_fall;
    logic          m_irq;
    int            m_cyc;
    int            m_span[NS];

    function automatic int ticks_in(input int s, input int n);
        return (n + 1) / TD - s / TD;
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0;
        m_irq = 1'b0; m_cyc = 0;
        for (int ch = 0; ch < NS; ch++) m_span[ch] = -1;
    endtask

    function automatic bit model_accepts(input int ch);
        int start;
        start = (m_span[ch] < 0) ? m_cyc : m_span[ch];
        return (m_s2[ch] != m_level[ch]) && ((m_cyc % TD) == TD - 1) && (ticks_in(start, m_cyc) == ST);
    endfunction

    task automatic model_step();
        logic [NS-1:0] set_r, set_f, clr;
        set_r = '0;
        set_f = '0;
        for (int ch = 0; ch < NS; ch++) begin
            if (m_s2[ch] == m_level[ch]) begin
                m_span[ch] = -1;
            end else begin
                if (model_accepts(ch)) begin
                    set_r[ch] = m_s2[ch];
                    set_f[ch] = ~m_s2[ch];
                    m_span[ch] = -1;
                end else if (m_span[ch] < 0) begin
                    m_span[ch] = m_cyc;
                end
            end
        end
        clr     = clr_valid ? clr_mask : '0;
        m_irq   = |((m_rise | m_fall) & irq_en);
        m_level = (m_level & ~(set_r | set_f)) | set_r;
        m_rise  = set_r | (m_rise & ~clr);
        m_fall  = set_f | (m_fall & ~clr);
        m_s2    = m_s1;
        m_s1    = sw_in;
        m_cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".level"}, 32'(sw_level), 32'(m_level));
        check({tag, ".rise"},  32'(sw_rise),  32'(m_rise));
        check({tag, ".fall"},  32'(sw_fall),  32'(m_fall));
        check({tag, ".irq"},   32'(irq),      32'(m_irq));
    endtask

    // Step until an expression-driven flag shows up; waits are bounded by max_cyc.
    task automatic wait_bit(input int which, input int ch, input int max_cyc, output int n, output bit hit);
        hit = 1'b0;
        n   = 0;
        while (!hit && n < max_cyc) begin
            cycle();
            n++;
            hit = (which == 0) ? sw_fall[ch] : sw_rise[ch];
        end
    endtask

    initial begin
        int  n;
        bit  hit;

        for (int k = 1; k <= 16; k++) begin
            tbl[k-1].sw    = 4'hF;
            tbl[k-1].en    = 4'h1;
            tbl[k-1].clr_v = (k == 14);
            tbl[k-1].clr_m = 4'hF;
            tbl[k-1].level = (k >= 12) ? 4'hF : 4'h0;
            tbl[k-1].rise  = (k == 12 || k == 13) ? 4'hF : 4'h0;
            tbl[k-1].fall  = 4'h0;
            tbl[k-1].irq   = (k == 13 || k == 14);
        end

        rst_n = 1'b0; sw_in = 4'hF; clr_valid = 1'b0; clr_mask = '0; irq_en = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst.level", 32'(sw_level), 0);
        check("rst.rise",  32'(sw_rise),  0);
        check("rst.fall",  32'(sw_fall),  0);
        check("rst.irq",   32'(irq),      0);
        rst_n = 1'b1;

        for (int k = 0; k < 16; k++) begin
            sw_in = tbl[k].sw; clr_valid = tbl[k].clr_v; clr_mask = tbl[k].clr_m; irq_en = tbl[k].en;
            cycle();
            check($sformatf("start%0d.level", k + 1), 32'(sw_level), 32'(tbl[k].level));
            check($sformatf("start%0d.rise", k + 1),  32'(sw_rise),  32'(tbl[k].rise));
            check($sformatf("start%0d.fall", k + 1),  32'(sw_fall),  32'(tbl[k].fall));
            check($sformatf("start%0d.irq", k + 1),   32'(irq),      32'(tbl[k].irq));
        end
        clr_valid = 1'b0;

        sw_in = 4'hE;
        repeat (6) cycle();
        sw_in = 4'hF;
        for (int k = 0; k < 20; k++) begin
            cycle();
            check("bounce.level0", 32'(sw_level[0]), 1);
            check("bounce.fall0",  32'(sw_fall[0]),  0);
        end

        irq_en = 4'b0001;
        sw_in  = 4'hE;
        wait_bit(0, 0, 20, n, hit);
        check("fall.seen", 32'(hit), 1);
        check("fall.within14", 32'(n <= 14), 1);
        cycle();
        check("fall.irq", 32'(irq), 1);
        clr_valid = 1'b1; clr_mask = 4'b0001;
        cycle();
        clr_valid = 1'b0; clr_mask = '0;
        check("clr.fall0", 32'(sw_fall[0]), 0);
        cycle();
        check("clr.irq", 32'(irq), 0);

        irq_en = '0;
        sw_in  = 4'hC;
        wait_bit(0, 1, 20, n, hit);
        check("coll.prefall", 32'(hit), 1);
        clr_valid = 1'b1; clr_mask = 4'b0010;
        cycle();
        clr_valid = 1'b0;
        sw_in = 4'hE;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            hit = model_accepts(1);
            clr_valid = hit;
            cycle();
        end
        clr_valid = 1'b0; clr_mask = '0;
        check("coll.found", 32'(hit), 1);
        check("coll.rise1", 32'(sw_rise[1]), 1);
        check_model("coll");

        sw_in = 4'hA;
        wait_bit(0, 2, 20, n, hit);
        check("mask.fall2", 32'(hit), 1);
        repeat (2) begin
            cycle();
            check("mask.irq_off", 32'(irq), 0);
        end
        irq_en = 4'b0100;
        cycle();
        check("mask.irq_on", 32'(irq), 1);

        irq_en = '0;
        clr_valid = 1'b1; clr_mask = 4'hF;
        cycle();
        clr_valid = 1'b0; clr_mask = '0;
        sw_in = 4'h2;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            cycle();
            hit = (m_span[3] >= 0) && (ticks_in(m_span[3], m_cyc - 1) == 2);
        end
        check("mid.two_ticks", 32'(hit), 1);
        check("mid.level_pre", 32'(sw_level[3]), 1);
        rst_n = 1'b0;
        sw_in = 4'h8;
        #1;
        model_reset();
        check("mid.level", 32'(sw_level), 0);
        check("mid.rise",  32'(sw_rise),  0);
        check("mid.fall",  32'(sw_fall),  0);
        check("mid.irq",   32'(irq),      0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            check($sformatf("mid%0d.rise", k),  32'(sw_rise),  (k == 12) ? 32'h8 : 32'h0);
            check($sformatf("mid%0d.level", k), 32'(sw_level), (k == 12) ? 32'h8 : 32'h0);
        end

        for (int k = 0; k < 3000; k++) begin
            for (int ch = 0; ch < NS; ch++)
                if ($urandom_range(0, 31) == 0) sw_in[ch] = ~sw_in[ch];
            if ((k % 500) > 450) sw_in[k % NS] = 1'($urandom_range(0, 1));
            clr_valid = ($urandom_range(0, 9) == 0);
            clr_mask  = NS'($urandom);
            if ($urandom_range(0, 15) == 0) irq_en = NS'($urandom);
            cycle();
            check_model("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
